// File: rtl/ff_conv_pkg.sv
// Shared mode encodings and the JK next-state function used by the
// multi-mode flip-flop bank and its storage cells.
package ff_conv_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b10;
  localparam logic [1:0] MODE_JK = 2'b11;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic n;
    case ({j, k})
      2'b00:   n = q;
      2'b01:   n = 1'b0;
      2'b10:   n = 1'b1;
      2'b11:   n = ~q;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit with asynchronous active-low reset.
module jk_cell
  import ff_conv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  // JK storage register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= jk_next(q_q, j, k);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ff_mode_bank.sv
// Runtime-selectable D/T/SR/JK register bank built on JK cells, with a
// sticky illegal-SR flag and a saturating change counter.
module ff_mode_bank
  import ff_conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_d;
  logic             illegal_s;
  logic             changed_s;
  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Excitation encoder: always uses the mode held before this edge
  always_comb begin
    j_s       = {WIDTH{1'b0}};
    k_s       = {WIDTH{1'b0}};
    illegal_s = 1'b0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode_q)
          MODE_D: begin
            j_s[i] = a[i];
            k_s[i] = ~a[i];
          end
          MODE_T: begin
            j_s[i] = a[i];
            k_s[i] = a[i];
          end
          MODE_SR: begin
            if (a[i] & b[i]) begin
              illegal_s = 1'b1;
            end else begin
              j_s[i] = a[i];
              k_s[i] = b[i];
            end
          end
          MODE_JK: begin
            j_s[i] = a[i];
            k_s[i] = b[i];
          end
          default: begin
            j_s[i] = 1'b0;
            k_s[i] = 1'b0;
          end
        endcase
      end
    end else begin
      illegal_s = 1'b0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      jk_cell u_cell (
        .clk (clk),
        .rst (rst),
        .j   (j_s[g]),
        .k   (k_s[g]),
        .q   (q_s[g])
      );
    end
  endgenerate

  // Next-state for mode, err and the change counter
  always_comb begin
    q_d = q_s;
    for (int i = 0; i < WIDTH; i++) begin
      q_d[i] = jk_next(q_s[i], j_s[i], k_s[i]);
    end
    changed_s = (q_d != q_s);
    mode_d    = mode_ld ? mode_in : mode_q;
    if (illegal_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (changed_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_D;
      err_q  <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      mode_q <= mode_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q       = q_s;
  assign mode    = mode_q;
  assign err     = err_q;
  assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_ff_mode_bank.sv
// Directed bench for ff_mode_bank: vector table plus reset and saturation sequences.
module tb_ff_mode_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_ld = 1'b0;
  logic [1:0] mode_in = 2'b00;
  logic       en = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       err_clr = 1'b0;

  logic [3:0] q8, q3;
  logic [1:0] mode8, mode3;
  logic       err8, err3;
  logic [7:0] cnt8;
  logic [2:0] cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ff_mode_bank #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en),
    .a(a), .b(b), .err_clr(err_clr),
    .q(q8), .mode(mode8), .err(err8), .chg_cnt(cnt8)
  );

  ff_mode_bank #(.WIDTH(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .en(en),
    .a(a), .b(b), .err_clr(err_clr),
    .q(q3), .mode(mode3), .err(err3), .chg_cnt(cnt3)
  );

  typedef struct {
    logic       mode_ld;
    logic [1:0] mode_in;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic       err_clr;
    logic [3:0] exp_q;
    logic [1:0] exp_mode;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [1:0] em,
                         input logic ee, input logic [7:0] ec);
    chk({tag, " q"}, {28'h0, q8}, {28'h0, eq});
    chk({tag, " mode"}, {30'h0, mode8}, {30'h0, em});
    chk({tag, " err"}, {31'h0, err8}, {31'h0, ee});
    chk({tag, " chg_cnt"}, {24'h0, cnt8}, {24'h0, ec});
  endtask

  initial begin
    // mode_ld, mode_in, en, a, b, err_clr, exp_q, exp_mode, exp_err, exp_cnt
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'hA, 4'h0, 1'b0, 4'hA, 2'b00, 1'b0, 8'd1});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h5, 4'hF, 1'b0, 4'h5, 2'b00, 1'b0, 8'd2});
    vecs.push_back('{1'b1, 2'b01, 1'b1, 4'hF, 4'h0, 1'b0, 4'hF, 2'b01, 1'b0, 8'd3});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h3, 4'hA, 1'b0, 4'hC, 2'b01, 1'b0, 8'd4});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h3, 4'h0, 1'b0, 4'hF, 2'b01, 1'b0, 8'd5});
    vecs.push_back('{1'b1, 2'b10, 1'b1, 4'h0, 4'h0, 1'b0, 4'hF, 2'b10, 1'b0, 8'd5});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 2'b10, 1'b0, 8'd6});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h9, 4'h3, 1'b0, 4'h8, 2'b10, 1'b1, 8'd7});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h0, 4'h0, 1'b1, 4'h8, 2'b10, 1'b0, 8'd7});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 4'h1, 4'h1, 1'b0, 4'h8, 2'b10, 1'b0, 8'd7});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'h1, 4'h1, 1'b1, 4'h8, 2'b10, 1'b1, 8'd7});
    vecs.push_back('{1'b1, 2'b11, 1'b1, 4'h6, 4'h8, 1'b0, 4'h6, 2'b11, 1'b1, 8'd8});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 4'hF, 4'hF, 1'b0, 4'h9, 2'b11, 1'b1, 8'd9});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b0, 2'b00, 1'b0, 4'hF, 4'hF, 1'b0, 4'h9, 2'b11, 1'b1, 8'd9});

    repeat (2) @(negedge clk);
    chk_all("reset", 4'h0, 2'b00, 1'b0, 8'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      mode_ld = vecs[i].mode_ld;
      mode_in = vecs[i].mode_in;
      en      = vecs[i].en;
      a       = vecs[i].a;
      b       = vecs[i].b;
      err_clr = vecs[i].err_clr;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_mode,
              vecs[i].exp_err, vecs[i].exp_cnt);
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle, then first edge after release
    mode_ld = 1'b0; en = 1'b0; err_clr = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 2'b00, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1; a = 4'h1; b = 4'h0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 4'h1, 2'b00, 1'b0, 8'd1);

    // Saturation: 10 changing edges, narrow counter saturates at 7
    @(negedge clk);
    rst = 1'b0;
    #1;
    rst = 1'b1;
    mode_ld = 1'b1; mode_in = 2'b01; en = 1'b1; a = 4'hF;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d cnt3", n), {29'h0, cnt3}, (n > 7) ? 32'd7 : n);
      chk($sformatf("sat%0d q", n), {28'h0, q3}, (n % 2 == 1) ? 32'hF : 32'h0);
      @(negedge clk);
      mode_ld = 1'b0;
    end
    chk("sat cnt8", {24'h0, cnt8}, 32'd10);
    chk("sat mode3", {30'h0, mode3}, 32'd1);
    chk("sat err3", {31'h0, err3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
